// File: rtl/udp_filter_cfg_ctrl_if.sv
// rtl/udp_filter_cfg_ctrl_if.sv - host/filter-side signal bundle for udp_filter_cfg_ctrl
//
// Purpose: groups the host configuration strobe, the counter clear, the two
// snooped filter valids and all status outputs of the controller.
// Ports (modport slave = controller, modport master = host/filter side):
//   cfg_wr_en, cfg_wr_port[15:0]  host write of a new destination port
//   cnt_clr                        clear all statistics counters
//   in_valid, out_valid            snooped filter stream_in / stream_out valid
//   active_port[15:0]              port value driving the filter
//   cfg_pending                    shadow holds an uncommitted value
//   pkt_count, match_count,
//   drop_count, runt_count         statistics counters, CNT_W bits each
interface udp_filter_cfg_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             cfg_wr_en;
    logic [15:0]      cfg_wr_port;
    logic             cnt_clr;
    logic             in_valid;
    logic             out_valid;
    logic [15:0]      active_port;
    logic             cfg_pending;
    logic [CNT_W-1:0] pkt_count;
    logic [CNT_W-1:0] match_count;
    logic [CNT_W-1:0] drop_count;
    logic [CNT_W-1:0] runt_count;

    modport master (
        output cfg_wr_en, cfg_wr_port, cnt_clr, in_valid, out_valid,
        input  active_port, cfg_pending, pkt_count, match_count, drop_count, runt_count
    );

    modport slave (
        input  cfg_wr_en, cfg_wr_port, cnt_clr, in_valid, out_valid,
        output active_port, cfg_pending, pkt_count, match_count, drop_count, runt_count
    );
endinterface

// File: rtl/udp_filter_cfg_ctrl.sv
// rtl/udp_filter_cfg_ctrl.sv - port configuration and statistics controller for one udp_packet_filter
//
// Purpose: holds the active destination port for the filter, buffers host
// writes in a shadow register and commits them only in an inter-packet gap,
// and counts packets, matched packets and dropped packets by snooping the
// filter's input and output valid.
// Optional feature: define UDP_CFG_RUNT_CNT_EN to count packets shorter than
// 42 bytes in runt_count; otherwise runt_count is tied to zero and no byte
// length register exists.
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   bus    udp_filter_cfg_ctrl_if.slave (config, snooped valids, status)
module udp_filter_cfg_ctrl #(
    parameter int          CNT_W        = 32,
    parameter logic [15:0] DEFAULT_PORT = 16'd0,
    parameter int          MIN_GAP      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    udp_filter_cfg_ctrl_if.slave  bus
);

    localparam int GW = $clog2(MIN_GAP + 1);

    typedef enum logic {
        S_GAP = 1'b0,
        S_PKT = 1'b1
    } state_t;

    state_t           state;
    logic [GW-1:0]    gap_cnt;
    logic             match_flag;
    logic [CNT_W-1:0] pkt_q;
    logic [CNT_W-1:0] match_q;
    logic [CNT_W-1:0] drop_q;
    logic [15:0]      active_q;
    logic [15:0]      shadow_q;
    logic             pending_q;
    logic             gap_ok;
    logic             eop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // The end-of-packet cycle is still in S_PKT, so it never counts as gap
    // and a commit can only land MIN_GAP idle cycles after it.
    assign gap_ok = (state == S_GAP) && !bus.in_valid && (gap_cnt >= GW'(MIN_GAP));
    assign eop    = (state == S_PKT) && !bus.in_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_GAP;
            gap_cnt    <= GW'(MIN_GAP);
            match_flag <= 1'b0;
            pkt_q      <= '0;
            match_q    <= '0;
            drop_q     <= '0;
        end else begin
            case (state)
                S_GAP: begin
                    if (bus.in_valid) begin
                        state      <= S_PKT;
                        match_flag <= 1'b0;
                        gap_cnt    <= '0;
                    end else if (gap_cnt < GW'(MIN_GAP)) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_PKT: begin
                    if (bus.in_valid) begin
                        match_flag <= match_flag | bus.out_valid;
                    end else begin
                        state <= S_GAP;
                    end
                end
            endcase

            if (bus.cnt_clr) begin
                pkt_q   <= '0;
                match_q <= '0;
                drop_q  <= '0;
            end else if (eop) begin
                pkt_q <= sat_inc(pkt_q);
                if (match_flag) begin
                    match_q <= sat_inc(match_q);
                end else begin
                    drop_q <= sat_inc(drop_q);
                end
            end
        end
    end

    // A write arriving in a gap_ok cycle bypasses the shadow and commits
    // directly; any other write parks in the shadow until the next gap_ok.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q  <= DEFAULT_PORT;
            shadow_q  <= DEFAULT_PORT;
            pending_q <= 1'b0;
        end else if (gap_ok && (pending_q || bus.cfg_wr_en)) begin
            active_q  <= bus.cfg_wr_en ? bus.cfg_wr_port : shadow_q;
            pending_q <= 1'b0;
            if (bus.cfg_wr_en) begin
                shadow_q <= bus.cfg_wr_port;
            end
        end else if (bus.cfg_wr_en) begin
            shadow_q  <= bus.cfg_wr_port;
            pending_q <= 1'b1;
        end
    end

`ifdef UDP_CFG_RUNT_CNT_EN
    logic [5:0]       byte_len;
    logic [CNT_W-1:0] runt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_len <= 6'd0;
            runt_q   <= '0;
        end else begin
            if (state == S_GAP && bus.in_valid) begin
                byte_len <= 6'd1;
            end else if (state == S_PKT && bus.in_valid && byte_len != 6'd63) begin
                byte_len <= byte_len + 6'd1;
            end

            // 42 = Ethernet 14 + IPv4 20 + UDP 8 header bytes.
            if (bus.cnt_clr) begin
                runt_q <= '0;
            end else if (eop && byte_len < 6'd42) begin
                runt_q <= sat_inc(runt_q);
            end
        end
    end

    assign bus.runt_count = runt_q;
`else
    assign bus.runt_count = '0;
`endif

    assign bus.active_port = active_q;
    assign bus.cfg_pending = pending_q;
    assign bus.pkt_count   = pkt_q;
    assign bus.match_count = match_q;
    assign bus.drop_count  = drop_q;

endmodule

// File: tb/tb_udp_filter_cfg_ctrl.sv
// tb/tb_udp_filter_cfg_ctrl.sv - self-checking bench for udp_filter_cfg_ctrl
module tb_udp_filter_cfg_ctrl;

    localparam int          CNT_W   = 6;
    localparam logic [15:0] DEF     = 16'h0042;
    localparam int          MIN_GAP = 2;
    localparam int          CMAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    udp_filter_cfg_ctrl_if #(.CNT_W(CNT_W)) bus ();

    udp_filter_cfg_ctrl #(
        .CNT_W       (CNT_W),
        .DEFAULT_PORT(DEF),
        .MIN_GAP     (MIN_GAP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: packets are tracked as runs of in_valid, gap
    // eligibility as the number of idle cycles seen since the last valid byte.
    int          m_active, m_shadow, m_pending;
    int          m_pkt, m_match, m_drop, m_runt;
    bit          m_in_pkt, m_pkt_hit;
    int          m_len;
    int          m_lows;

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_step(input bit iv, input bit ov, input bit wr,
                              input int port, input bit clr, input bit rst);
        bit ok;
        bit end_pkt;
        if (rst) begin
            m_active = DEF; m_shadow = DEF; m_pending = 0;
            m_pkt = 0; m_match = 0; m_drop = 0; m_runt = 0;
            m_in_pkt = 0; m_pkt_hit = 0; m_len = 0;
            m_lows = 1000;
            return;
        end
        ok      = !iv && (m_lows > MIN_GAP);
        end_pkt = m_in_pkt && !iv;
        if (wr && !ok) begin
            m_shadow = port; m_pending = 1;
        end else if (ok && (m_pending != 0 || wr)) begin
            m_active = wr ? port : m_shadow;
            if (wr) m_shadow = port;
            m_pending = 0;
        end
        if (clr) begin
            m_pkt = 0; m_match = 0; m_drop = 0; m_runt = 0;
        end else if (end_pkt) begin
            m_pkt = sat(m_pkt);
            if (m_pkt_hit) m_match = sat(m_match);
            else           m_drop  = sat(m_drop);
`ifdef UDP_CFG_RUNT_CNT_EN
            if (m_len < 42) m_runt = sat(m_runt);
`endif
        end
        if (iv) begin
            if (!m_in_pkt) begin
                m_in_pkt = 1; m_len = 1; m_pkt_hit = 0;
            end else begin
                m_len++;
                m_pkt_hit = m_pkt_hit | ov;
            end
        end else begin
            m_in_pkt = 0;
        end
        m_lows = iv ? 0 : ((m_lows >= 1000) ? 1000 : m_lows + 1);
    endtask

    task automatic cyc(input bit iv, input bit ov, input bit wr, input logic [15:0] port,
                       input bit clr, input bit rst);
        bus.in_valid    = iv;
        bus.out_valid   = ov;
        bus.cfg_wr_en   = wr;
        bus.cfg_wr_port = port;
        bus.cnt_clr     = clr;
        reset           = rst;
        @(posedge clk);
        model_step(iv, ov, wr, int'(port), clr, rst);
        #1;
        chk("active",  32'(bus.active_port), 32'(m_active));
        chk("pending", 32'(bus.cfg_pending), 32'(m_pending));
        chk("pkt",     32'(bus.pkt_count),   32'(m_pkt));
        chk("match",   32'(bus.match_count), 32'(m_match));
        chk("drop",    32'(bus.drop_count),  32'(m_drop));
        chk("runt",    32'(bus.runt_count),  32'(m_runt));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 16'h0, 0, 0);
    endtask

    // Sends only the in_valid bytes; the caller supplies the end-of-packet cycle.
    task automatic send_pkt(input int len, input bit ov,
                            input int wa, input logic [15:0] pa,
                            input int wb, input logic [15:0] pb);
        for (int i = 0; i < len; i++) begin
            bit hit;
            hit = ov && (i >= 2) && (i < len - 1);
            if (i == wa)      cyc(1, hit, 1, pa, 0, 0);
            else if (i == wb) cyc(1, hit, 1, pb, 0, 0);
            else              cyc(1, hit, 0, 16'h0, 0, 0);
        end
    endtask

    initial begin
        bus.in_valid = 0; bus.out_valid = 0; bus.cfg_wr_en = 0;
        bus.cfg_wr_port = 0; bus.cnt_clr = 0; reset = 1;

        // reset state
        cyc(0, 0, 0, 16'h0, 0, 1);
        cyc(0, 0, 0, 16'h0, 0, 1);
        chk("rst_active", 32'(bus.active_port), 32'(DEF));
        chk("rst_pending", 32'(bus.cfg_pending), 32'd0);
        chk("rst_pkt", 32'(bus.pkt_count), 32'd0);

        // write in a gap commits next cycle
        cyc(0, 0, 1, 16'h1234, 0, 0);
        chk("t1_active", 32'(bus.active_port), 32'h1234);
        chk("t1_pending", 32'(bus.cfg_pending), 32'd0);

        // write during a 64-byte packet waits for the gap
        idle(3);
        send_pkt(64, 0, 9, 16'h5678, -1, 16'h0);
        chk("t2_pend_in_pkt", 32'(bus.cfg_pending), 32'd1);
        cyc(0, 0, 0, 16'h0, 0, 0);
        idle(2);
        chk("t2_hold", 32'(bus.active_port), 32'h1234);
        idle(1);
        chk("t2_commit", 32'(bus.active_port), 32'h5678);
        chk("t2_pend_clr", 32'(bus.cfg_pending), 32'd0);

        // last write wins; write on end-of-packet goes pending
        send_pkt(8, 0, 2, 16'hAAAA, 5, 16'hBBBB);
        idle(5);
        chk("t3_last_wins", 32'(bus.active_port), 32'hBBBB);
        send_pkt(6, 0, -1, 16'h0, -1, 16'h0);
        cyc(0, 0, 1, 16'hCCCC, 0, 0);
        chk("t3_eop_pend", 32'(bus.cfg_pending), 32'd1);
        chk("t3_eop_hold", 32'(bus.active_port), 32'hBBBB);
        idle(5);
        chk("t3_eop_commit", 32'(bus.active_port), 32'hCCCC);

        // match/drop accounting and clear beating an increment
        cyc(0, 0, 0, 16'h0, 1, 0);
        send_pkt(10, 1, -1, 16'h0, -1, 16'h0); idle(3);
        send_pkt(10, 0, -1, 16'h0, -1, 16'h0); idle(3);
        send_pkt(10, 1, -1, 16'h0, -1, 16'h0); idle(3);
        chk("t4_pkt", 32'(bus.pkt_count), 32'd3);
        chk("t4_match", 32'(bus.match_count), 32'd2);
        chk("t4_drop", 32'(bus.drop_count), 32'd1);
        send_pkt(10, 1, -1, 16'h0, -1, 16'h0);
        cyc(0, 0, 0, 16'h0, 1, 0);
        chk("t4_clr_pkt", 32'(bus.pkt_count), 32'd0);
        chk("t4_clr_match", 32'(bus.match_count), 32'd0);

        // saturation, then reset mid-packet with a pending write
        for (int p = 0; p < CMAX + 6; p++) begin
            send_pkt(2, 0, -1, 16'h0, -1, 16'h0);
            idle(1);
        end
        chk("t5_drop_sat", 32'(bus.drop_count), 32'(CMAX));
        chk("t5_pkt_sat", 32'(bus.pkt_count), 32'(CMAX));
        send_pkt(12, 0, 4, 16'h9999, -1, 16'h0);
        cyc(0, 0, 0, 16'h0, 0, 1);
        idle(4);
        chk("t5_rst_active", 32'(bus.active_port), 32'(DEF));
        chk("t5_rst_pending", 32'(bus.cfg_pending), 32'd0);
        chk("t5_rst_drop", 32'(bus.drop_count), 32'd0);

        // runt boundary: 20 bytes is a runt, 42 bytes is not
        send_pkt(20, 0, -1, 16'h0, -1, 16'h0); idle(3);
        send_pkt(42, 0, -1, 16'h0, -1, 16'h0); idle(3);
        chk("t6_drop", 32'(bus.drop_count), 32'd2);
`ifdef UDP_CFG_RUNT_CNT_EN
        chk("t6_runt", 32'(bus.runt_count), 32'd1);
`else
        chk("t6_runt", 32'(bus.runt_count), 32'd0);
`endif

        // randomized traffic against the model
        for (int p = 0; p < 150; p++) begin
            int len;
            int gap;
            bit ov_en;
            len   = $urandom_range(1, 70);
            gap   = $urandom_range(1, 6);
            ov_en = $urandom_range(0, 1);
            for (int i = 0; i < len + gap; i++) begin
                bit iv;
                bit ov;
                bit wr;
                bit clr;
                bit rst;
                iv  = (i < len);
                ov  = iv && ov_en && ($urandom_range(0, 3) == 0);
                wr  = ($urandom_range(0, 7) == 0);
                clr = ($urandom_range(0, 99) == 0);
                rst = ($urandom_range(0, 599) == 0);
                cyc(iv, ov, wr, 16'($urandom), clr, rst);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
